// File: rtl/program_test_sequencer_pkg.sv
// Shared types and defaults for the program test sequencer.
package program_test_sequencer_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StResetCore,
        StRun,
        StCheck,
        StDone
    } state_e;

    localparam int unsigned DefaultResetCycles = 2;
    localparam int unsigned DefaultMaxCycles   = 100;
    localparam int unsigned RegZero            = 0;

endpackage

// File: rtl/program_test_sequencer_if.sv
// Bench/core-facing signal bundle of the program test sequencer.
interface program_test_sequencer_if #(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned REG_ADDR_WIDTH  = 5,
    parameter int unsigned CHECK_IDX_WIDTH = 2,
    parameter int unsigned CYCLE_WIDTH     = 16
);
    logic                       start;
    logic                       cfg_we;
    logic [CHECK_IDX_WIDTH-1:0] cfg_idx;
    logic                       cfg_valid;
    logic [REG_ADDR_WIDTH-1:0]  cfg_rd;
    logic [DATA_WIDTH-1:0]      cfg_data;
    logic                       core_reset;
    logic                       commit_valid;
    logic [REG_ADDR_WIDTH-1:0]  commit_rd;
    logic [DATA_WIDTH-1:0]      commit_data;
    logic                       halt;
    logic                       busy;
    logic                       done;
    logic                       pass;
    logic                       fail_timeout;
    logic [CHECK_IDX_WIDTH:0]   mismatch_count;
    logic [CHECK_IDX_WIDTH-1:0] first_fail_idx;
    logic [CYCLE_WIDTH-1:0]     cycle_count;

    modport master (
        output start, cfg_we, cfg_idx, cfg_valid, cfg_rd, cfg_data,
        output commit_valid, commit_rd, commit_data, halt,
        input  core_reset, busy, done, pass, fail_timeout, mismatch_count,
        input  first_fail_idx, cycle_count
    );

    modport slave (
        input  start, cfg_we, cfg_idx, cfg_valid, cfg_rd, cfg_data,
        input  commit_valid, commit_rd, commit_data, halt,
        output core_reset, busy, done, pass, fail_timeout, mismatch_count,
        output first_fail_idx, cycle_count
    );

endinterface

// File: rtl/program_test_sequencer_shadow_regfile.sv
// Shadow copy of the core register file: one write port, async read, r0 reads as zero.
module program_test_sequencer_shadow_regfile
    import program_test_sequencer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      we,
    input  logic [REG_ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]     wdata,
    input  logic [REG_ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0]     rdata
);
    localparam int unsigned NumRegs = 2 ** REG_ADDR_WIDTH;
    localparam logic [REG_ADDR_WIDTH-1:0] R0 = REG_ADDR_WIDTH'(RegZero);

    logic [DATA_WIDTH-1:0] regs_q [NumRegs];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NumRegs; i++) regs_q[i] <= '0;
        end else if (clear) begin
            for (int i = 0; i < NumRegs; i++) regs_q[i] <= '0;
        end else if (we && (waddr != R0)) begin
            regs_q[waddr] <= wdata;
        end
    end

    assign rdata = (raddr == R0) ? '0 : regs_q[raddr];

endmodule

// File: rtl/program_test_sequencer.sv
// Sequences a core through reset, run and result check, and reports pass/fail against a
// loadable table of expected register values.
module program_test_sequencer
    import program_test_sequencer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned REG_ADDR_WIDTH  = 5,
    parameter int unsigned NUM_CHECKS      = 4,
    parameter int unsigned CHECK_IDX_WIDTH = 2,
    parameter int unsigned RESET_CYCLES    = DefaultResetCycles,
    parameter int unsigned MAX_CYCLES      = DefaultMaxCycles,
    parameter int unsigned CYCLE_WIDTH     = 16
) (
    input logic                     clk,
    input logic                     reset,
    program_test_sequencer_if.slave bus
);
    localparam int unsigned RstCntWidth = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [RstCntWidth-1:0]     RstCntLast  = RstCntWidth'(RESET_CYCLES - 1);
    localparam logic [CHECK_IDX_WIDTH-1:0] IdxLast     = CHECK_IDX_WIDTH'(NUM_CHECKS - 1);
    localparam logic [CYCLE_WIDTH-1:0]     CycleBudget = CYCLE_WIDTH'(MAX_CYCLES);

    state_e                     state_q;
    logic [RstCntWidth-1:0]     rst_cnt_q;
    logic [CHECK_IDX_WIDTH-1:0] check_idx_q;
    logic [CYCLE_WIDTH-1:0]     cycle_count_q;
    logic [CHECK_IDX_WIDTH:0]   mismatch_q;
    logic [CHECK_IDX_WIDTH-1:0] first_fail_q;
    logic done_q, pass_q, timeout_q, core_reset_q, busy_q;

    logic                      tbl_valid_q [NUM_CHECKS];
    logic [REG_ADDR_WIDTH-1:0] tbl_rd_q    [NUM_CHECKS];
    logic [DATA_WIDTH-1:0]     tbl_data_q  [NUM_CHECKS];

    logic                     idle_or_done, start_ok;
    logic [DATA_WIDTH-1:0]    shadow_rdata;
    logic [CYCLE_WIDTH-1:0]   cycle_inc;
    logic                     budget_hit, entry_fail;
    logic [CHECK_IDX_WIDTH:0] mismatch_next;

    assign idle_or_done = (state_q == StIdle) || (state_q == StDone);
    assign start_ok     = idle_or_done && bus.start;

    program_test_sequencer_shadow_regfile #(
        .DATA_WIDTH    (DATA_WIDTH),
        .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
    ) u_shadow (
        .clk  (clk),
        .reset(reset),
        .clear(start_ok),
        .we   ((state_q == StRun) && bus.commit_valid),
        .waddr(bus.commit_rd),
        .wdata(bus.commit_data),
        .raddr(tbl_rd_q[check_idx_q]),
        .rdata(shadow_rdata)
    );

    always_comb begin
        cycle_inc     = (cycle_count_q == '1) ? cycle_count_q : cycle_count_q + 1'b1;
        budget_hit    = cycle_inc >= CycleBudget;
        entry_fail    = tbl_valid_q[check_idx_q] && (shadow_rdata != tbl_data_q[check_idx_q]);
        mismatch_next = mismatch_q + (CHECK_IDX_WIDTH + 1)'(entry_fail);
    end

    // Table is only writable while no run is in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CHECKS; i++) begin
                tbl_valid_q[i] <= 1'b0;
                tbl_rd_q[i]    <= '0;
                tbl_data_q[i]  <= '0;
            end
        end else if (bus.cfg_we && idle_or_done && (32'(bus.cfg_idx) < NUM_CHECKS)) begin
            tbl_valid_q[bus.cfg_idx] <= bus.cfg_valid;
            tbl_rd_q[bus.cfg_idx]    <= bus.cfg_rd;
            tbl_data_q[bus.cfg_idx]  <= bus.cfg_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            rst_cnt_q     <= '0;
            check_idx_q   <= '0;
            cycle_count_q <= '0;
            mismatch_q    <= '0;
            first_fail_q  <= '0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            timeout_q     <= 1'b0;
            core_reset_q  <= 1'b1;
            busy_q        <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (bus.start) begin
                        state_q       <= StResetCore;
                        rst_cnt_q     <= '0;
                        check_idx_q   <= '0;
                        cycle_count_q <= '0;
                        mismatch_q    <= '0;
                        first_fail_q  <= '0;
                        done_q        <= 1'b0;
                        pass_q        <= 1'b0;
                        timeout_q     <= 1'b0;
                        core_reset_q  <= 1'b1;
                        busy_q        <= 1'b1;
                    end
                end
                StResetCore: begin
                    if (rst_cnt_q == RstCntLast) begin
                        state_q      <= StRun;
                        core_reset_q <= 1'b0;
                    end else begin
                        rst_cnt_q <= rst_cnt_q + 1'b1;
                    end
                end
                StRun: begin
                    cycle_count_q <= cycle_inc;
                    // Halt takes priority over an expiring budget.
                    if (bus.halt) begin
                        state_q      <= StCheck;
                        check_idx_q  <= '0;
                        core_reset_q <= 1'b1;
                    end else if (budget_hit) begin
                        state_q      <= StDone;
                        timeout_q    <= 1'b1;
                        done_q       <= 1'b1;
                        pass_q       <= 1'b0;
                        busy_q       <= 1'b0;
                        core_reset_q <= 1'b1;
                    end
                end
                StCheck: begin
                    mismatch_q <= mismatch_next;
                    if (entry_fail && (mismatch_q == '0)) first_fail_q <= check_idx_q;
                    if (check_idx_q == IdxLast) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                        pass_q  <= !timeout_q && (mismatch_next == '0);
                        busy_q  <= 1'b0;
                    end else begin
                        check_idx_q <= check_idx_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.core_reset     = core_reset_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.pass           = pass_q;
    assign bus.fail_timeout   = timeout_q;
    assign bus.mismatch_count = mismatch_q;
    assign bus.first_fail_idx = first_fail_q;
    assign bus.cycle_count    = cycle_count_q;

endmodule

// File: tb/tb_program_test_sequencer.sv
// Randomized self-checking bench: a run-timeline model predicts every output each cycle.
module tb_program_test_sequencer;
    localparam int unsigned DW = 32, AW = 5, NC = 4, IW = 2, RC = 2, MC = 20, CW = 16;
    localparam int MaxRun = 32;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    program_test_sequencer_if #(
        .DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .CHECK_IDX_WIDTH(IW), .CYCLE_WIDTH(CW)
    ) bus ();

    program_test_sequencer #(
        .DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .NUM_CHECKS(NC), .CHECK_IDX_WIDTH(IW),
        .RESET_CYCLES(RC), .MAX_CYCLES(MC), .CYCLE_WIDTH(CW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: expected table, commit schedule per RUN cycle, and expected run outcome.
    bit          m_valid [NC];
    int unsigned m_rd    [NC];
    int unsigned m_data  [NC];
    bit          cm_v    [MaxRun + 1];
    int unsigned cm_rd   [MaxRun + 1];
    int unsigned cm_d    [MaxRun + 1];

    bit chk_en = 1'b0;
    int phase_t = 0;  // cycles since the accepted start edge; 0 = idle after reset
    int e_len = 0, e_mm = 0, e_ffi = 0;
    bit e_to = 1'b0, e_pass = 1'b0;

    int t_run_end, t_done, x_cc, x_mm, x_ff;
    bit x_cr, x_busy, x_dn, x_ps, x_tf, x_res;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0d actual=%0h expected=%0h", name, phase_t, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            t_run_end = RC + e_len;
            t_done    = t_run_end + (e_to ? 1 : NC + 1);
            x_cr = 1; x_busy = 0; x_dn = 0; x_ps = 0; x_tf = 0; x_res = 1;
            x_cc = 0; x_mm = 0; x_ff = 0;
            if (phase_t == 0) begin
                x_busy = 0;
            end else if (phase_t <= RC) begin
                x_busy = 1;
            end else if (phase_t <= t_run_end) begin
                x_cr = 0; x_busy = 1; x_cc = phase_t - RC - 1;
            end else if (phase_t < t_done) begin
                x_busy = 1; x_cc = e_len; x_res = 0;
            end else begin
                x_dn = 1; x_cc = e_len; x_ps = e_pass; x_tf = e_to; x_mm = e_mm; x_ff = e_ffi;
            end
            check("core_reset", 64'(bus.core_reset), 64'(x_cr));
            check("busy", 64'(bus.busy), 64'(x_busy));
            check("done", 64'(bus.done), 64'(x_dn));
            check("pass", 64'(bus.pass), 64'(x_ps));
            check("fail_timeout", 64'(bus.fail_timeout), 64'(x_tf));
            check("cycle_count", 64'(bus.cycle_count), 64'(x_cc));
            if (x_res) begin
                check("mismatch_count", 64'(bus.mismatch_count), 64'(x_mm));
                check("first_fail_idx", 64'(bus.first_fail_idx), 64'(x_ff));
            end
        end
    end

    task automatic drive_idle();
        bus.start = 0; bus.cfg_we = 0; bus.cfg_idx = '0; bus.cfg_valid = 0;
        bus.cfg_rd = '0; bus.cfg_data = '0; bus.commit_valid = 0; bus.commit_rd = '0;
        bus.commit_data = '0; bus.halt = 0;
    endtask

    task automatic cfg_write(input int idx, input bit v, input int unsigned rd,
                             input int unsigned d);
        bus.cfg_we = 1; bus.cfg_idx = IW'(idx); bus.cfg_valid = v;
        bus.cfg_rd = AW'(rd); bus.cfg_data = DW'(d);
        @(posedge clk); #1;
        bus.cfg_we = 0;
        m_valid[idx] = v; m_rd[idx] = rd; m_data[idx] = d;
    endtask

    task automatic clear_commits();
        for (int k = 0; k <= MaxRun; k++) cm_v[k] = 0;
    endtask

    task automatic set_commit(input int k, input int unsigned rd, input int unsigned d);
        cm_v[k] = 1; cm_rd[k] = rd; cm_d[k] = d;
    endtask

    // halt_cyc: RUN cycle (1-based) in which halt is raised; 0 or > MC means never.
    task automatic do_run(input int halt_cyc, input bit noise);
        int L, mm, ffi, k, td;
        bit to;
        int unsigned sh [32];
        to = !(halt_cyc >= 1 && halt_cyc <= int'(MC));
        L  = to ? MC : halt_cyc;
        for (int i = 0; i < 32; i++) sh[i] = 0;
        for (int c = 1; c <= L; c++) if (cm_v[c] && cm_rd[c] != 0) sh[cm_rd[c]] = cm_d[c];
        mm = 0; ffi = 0;
        if (!to) begin
            for (int i = 0; i < NC; i++) begin
                if (m_valid[i] && sh[m_rd[i]] != m_data[i]) begin
                    if (mm == 0) ffi = i;
                    mm++;
                end
            end
        end
        bus.start = 1;
        @(posedge clk); #1;
        bus.start = 0;
        e_len = L; e_to = to; e_mm = mm; e_ffi = ffi; e_pass = !to && mm == 0;
        phase_t = 1;
        td = RC + L + (to ? 1 : NC + 1);
        while (phase_t < td + 2) begin
            drive_idle();
            k = phase_t - RC;
            if (k >= 1 && k <= L) begin
                bus.commit_valid = cm_v[k]; bus.commit_rd = AW'(cm_rd[k]);
                bus.commit_data = DW'(cm_d[k]); bus.halt = (k == halt_cyc);
            end
            if (noise && phase_t < td && $urandom_range(0, 2) == 0) begin
                bus.start = 1; bus.cfg_we = 1; bus.cfg_idx = IW'($urandom_range(0, 3));
                bus.cfg_valid = 1; bus.cfg_rd = AW'($urandom_range(0, 7));
                bus.cfg_data = DW'($urandom_range(100, 200));
            end
            @(posedge clk); #1;
            phase_t++;
        end
        drive_idle();
    endtask

    initial begin
        drive_idle();
        for (int i = 0; i < NC; i++) begin m_valid[i] = 0; m_rd[i] = 0; m_data[i] = 0; end
        clear_commits();
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1;
        check("rst_core_reset", 64'(bus.core_reset), 64'd1);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_cycle_count", 64'(bus.cycle_count), 64'd0);
        reset = 1;
        @(posedge clk); #1;

        // Basic passing run.
        cfg_write(0, 1, 1, 5);
        cfg_write(1, 1, 2, 8);
        set_commit(3, 1, 5); set_commit(4, 2, 8);
        do_run(6, 0);
        check("t1_pass", 64'(bus.pass), 64'd1);
        check("t1_mm", 64'(bus.mismatch_count), 64'd0);
        check("t1_cc", 64'(bus.cycle_count), 64'd6);

        // Wrong value for r2.
        set_commit(4, 2, 9);
        do_run(6, 0);
        check("t2_pass", 64'(bus.pass), 64'd0);
        check("t2_mm", 64'(bus.mismatch_count), 64'd1);
        check("t2_ffi", 64'(bus.first_fail_idx), 64'd1);

        // Back-to-back with correct commits, busy start/cfg noise ignored.
        set_commit(4, 2, 8);
        do_run(6, 1);
        check("t3_pass", 64'(bus.pass), 64'd1);
        check("t3_mm", 64'(bus.mismatch_count), 64'd0);

        // Timeout.
        do_run(0, 0);
        check("t4_timeout", 64'(bus.fail_timeout), 64'd1);
        check("t4_cc", 64'(bus.cycle_count), 64'd20);
        check("t4_pass", 64'(bus.pass), 64'd0);

        // Halt exactly at the budget: halt wins.
        do_run(20, 0);
        check("t5_timeout", 64'(bus.fail_timeout), 64'd0);
        check("t5_pass", 64'(bus.pass), 64'd1);

        // r0 writes ignored; commit in halt cycle is applied.
        cfg_write(2, 1, 0, 0);
        cfg_write(3, 1, 3, 4);
        set_commit(2, 0, 7); set_commit(5, 3, 4);
        do_run(5, 0);
        check("t6_pass", 64'(bus.pass), 64'd1);

        // Reset mid-run.
        bus.start = 1;
        @(posedge clk); #1;
        bus.start = 0;
        e_len = MC; e_to = 1; phase_t = 1;
        repeat (RC + 3) begin
            @(posedge clk); #1;
            phase_t++;
        end
        #1;
        reset = 0; phase_t = 0;
        for (int i = 0; i < NC; i++) m_valid[i] = 0;
        #1;
        check("mr_core_reset", 64'(bus.core_reset), 64'd1);
        check("mr_done", 64'(bus.done), 64'd0);
        check("mr_cc", 64'(bus.cycle_count), 64'd0);
        check("mr_busy", 64'(bus.busy), 64'd0);
        @(posedge clk); #1;
        reset = 1;
        @(posedge clk); #1;
        do_run(4, 0);
        check("mr_after_pass", 64'(bus.pass), 64'd1);

        // Randomized runs.
        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < NC; i++)
                cfg_write(i, 1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 3));
            clear_commits();
            for (int k = 1; k <= MaxRun; k++)
                if ($urandom_range(0, 1) == 1)
                    set_commit(k, $urandom_range(0, 7), $urandom_range(0, 3));
            do_run((r % 6 == 0) ? 0 : int'($urandom_range(1, 24)), 1'($urandom_range(0, 1)));
        end

        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
